// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single data memory.
// Port A is the core load/store path and port B is debug/DMA. Each accepted
// request takes three cycles: IDLE (arbitrate and latch), ACCESS (drive memory),
// RESP (return response). Misaligned, illegal-type and out-of-range accesses are
// rejected without touching memory.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration between the
// ports. Without it, port A has fixed priority.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [2:0]  a_type,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [2:0]  b_type,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_rw_type,
    output logic [31:0] mem_dat_i,
    input  logic [31:0] mem_dat_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic        pick_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_type;
    logic [31:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
    logic        last_q, last_d;
`endif

    // An access is rejected for an illegal type, a misaligned half/word, or an
    // address at or beyond the end of data memory.
    function automatic logic access_error(input logic [31:0] addr, input logic [2:0] typ);
        logic bad;
        case (typ)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = |addr[1:0];
            default:        bad = 1'b1;
        endcase
        return bad | (addr >= ADDR_LIMIT);
    endfunction

    // Choose the winning port among the current requests and mux its fields.
`ifdef DMEM_ARB_RR_EN
    always_comb begin
        pick_b    = b_req & (~a_req | ~last_q);
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_type  = pick_b ? b_type  : a_type;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end
`else
    always_comb begin
        pick_b    = b_req & ~a_req;
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_type  = pick_b ? b_type  : a_type;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end
`endif

    // Next-state logic: latch the winner in IDLE, capture load data leaving ACCESS.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        type_d    = type_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    state_d = ACCESS;
                    port_d  = pick_b;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    type_d  = sel_type;
                    wdata_d = sel_wdata;
                    err_d   = access_error(sel_addr, sel_type);
`ifdef DMEM_ARB_RR_EN
                    last_d  = pick_b;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (port_q) begin
                    b_rdata_d = (we_q | err_q) ? 32'h0 : mem_dat_o;
                end else begin
                    a_rdata_d = (we_q | err_q) ? 32'h0 : mem_dat_o;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any access in flight and clears all results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            type_q    <= 3'b000;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            a_rdata_q <= 32'h0;
            b_rdata_q <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // Handshake and memory outputs decode purely from registered state.
    always_comb begin
        a_gnt       = (state_q == ACCESS) & ~port_q;
        b_gnt       = (state_q == ACCESS) &  port_q;
        a_rvalid    = (state_q == RESP)   & ~port_q;
        b_rvalid    = (state_q == RESP)   &  port_q;
        a_err       = a_rvalid & err_q;
        b_err       = b_rvalid & err_q;
        a_rdata     = a_rdata_q;
        b_rdata     = b_rdata_q;
        mem_wr_en   = (state_q == ACCESS) & we_q & ~err_q;
        mem_addr    = (state_q == ACCESS) ? addr_q  : 32'h0;
        mem_rw_type = (state_q == ACCESS) ? type_q  : 3'b000;
        mem_dat_i   = (state_q == ACCESS) ? wdata_q : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks for dmem_arbiter. Expected arbitration
// order follows DMEM_ARB_RR_EN when the bench is built with that macro.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [2:0]  a_type, b_type;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_dat_i, mem_dat_o;
    logic [2:0]  mem_rw_type;

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(.ADDR_LIMIT(32'h0000_0400)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_type(a_type), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_type(b_type), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_rw_type(mem_rw_type),
        .mem_dat_i(mem_dat_i), .mem_dat_o(mem_dat_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access on a single port through IDLE, ACCESS, RESP and report what was seen.
    task automatic run_access(input bit port_b, input logic we, input logic [31:0] addr,
                              input logic [2:0] typ, input logic [31:0] wdata, input logic [31:0] rdval,
                              output logic gnt_seen, output int wr_cnt, output logic rv_seen,
                              output logic err_seen, output logic [31:0] rdata_seen);
        @(negedge clk);
        mem_dat_o = rdval;
        if (port_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_type = typ; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_type = typ; a_wdata = wdata;
        end
        @(negedge clk);
        gnt_seen = port_b ? (b_gnt & ~a_gnt) : (a_gnt & ~b_gnt);
        wr_cnt   = int'(mem_wr_en);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        rv_seen    = port_b ? b_rvalid : a_rvalid;
        err_seen   = port_b ? b_err : a_err;
        rdata_seen = port_b ? b_rdata : a_rdata;
        wr_cnt     = wr_cnt + int'(mem_wr_en);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_wr_en} !== 7'b0)
            $display("[TB] FAIL reset_flags got %b exp 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_wr_en});
        else passed++;
        total++;
        if ({a_rdata, b_rdata} !== 64'h0)
            $display("[TB] FAIL reset_rdata got %h exp 0", {a_rdata, b_rdata});
        else passed++;
        total++;
        if ({mem_addr, mem_rw_type, mem_dat_i} !== 67'h0)
            $display("[TB] FAIL reset_mem got %h exp 0", {mem_addr, mem_rw_type, mem_dat_i});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_en} !== 5'b0)
            $display("[TB] FAIL idle_no_req got %b exp 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_en});
        else passed++;
    endtask

    task automatic test_load_word();
        logic g, rv, er;
        int wc;
        logic [31:0] rd;
        run_access(1'b0, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, g, wc, rv, er, rd);
        total++;
        if (g !== 1'b1) $display("[TB] FAIL load_gnt got %b exp 1", g); else passed++;
        total++;
        if ({rv, er} !== 2'b10) $display("[TB] FAIL load_rvalid_err got %b exp 10", {rv, er}); else passed++;
        total++;
        if (rd !== 32'hDEADBEEF) $display("[TB] FAIL load_rdata got %h exp deadbeef", rd); else passed++;
        total++;
        if (wc !== 0) $display("[TB] FAIL load_no_write got %0d exp 0", wc); else passed++;
        total++;
        if ({a_rvalid, a_rdata} !== {1'b0, 32'hDEADBEEF})
            $display("[TB] FAIL load_rdata_hold got %h exp 0deadbeef", {a_rvalid, a_rdata});
        else passed++;
    endtask

    task automatic test_store_half_b();
        @(negedge clk);
        mem_dat_o = 32'hFFFF_FFFF;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h22; b_type = 3'b001; b_wdata = 32'h1234;
        @(negedge clk);
        total++;
        if ({b_gnt, a_gnt, mem_wr_en} !== 3'b101)
            $display("[TB] FAIL store_access_flags got %b exp 101", {b_gnt, a_gnt, mem_wr_en});
        else passed++;
        total++;
        if ({mem_addr, mem_rw_type, mem_dat_i} !== {32'h22, 3'b001, 32'h1234})
            $display("[TB] FAIL store_mem_bus got %h exp %h", {mem_addr, mem_rw_type, mem_dat_i}, {32'h22, 3'b001, 32'h1234});
        else passed++;
        b_req = 1'b0; b_addr = 32'h99; b_wdata = 32'h0;
        @(negedge clk);
        total++;
        if ({b_rvalid, b_err, a_rvalid, mem_wr_en} !== 4'b1000)
            $display("[TB] FAIL store_resp_flags got %b exp 1000", {b_rvalid, b_err, a_rvalid, mem_wr_en});
        else passed++;
        total++;
        if (b_rdata !== 32'h0) $display("[TB] FAIL store_rdata got %h exp 0", b_rdata); else passed++;
        total++;
        if (mem_addr !== 32'h0) $display("[TB] FAIL store_mem_idle got %h exp 0", mem_addr); else passed++;
        @(negedge clk);
        total++;
        if ({b_rvalid, a_rdata} !== {1'b0, 32'hDEADBEEF})
            $display("[TB] FAIL store_after got %h exp 0deadbeef", {b_rvalid, a_rdata});
        else passed++;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] rdval;
        logic        exp_err;
    } err_vec_t;

    task automatic test_errors();
        err_vec_t vecs[7];
        logic g, rv, er;
        int wc;
        logic [31:0] rd;
        int exp_wr;
        logic [31:0] exp_rd;
        vecs[0] = '{1'b1, 32'h013, 3'b010, 32'h1111_1111, 1'b1};
        vecs[1] = '{1'b1, 32'h400, 3'b010, 32'h2222_2222, 1'b1};
        vecs[2] = '{1'b0, 32'h3FC, 3'b010, 32'h0BAD_F00D, 1'b0};
        vecs[3] = '{1'b0, 32'h000, 3'b011, 32'h3333_3333, 1'b1};
        vecs[4] = '{1'b0, 32'h021, 3'b101, 32'h4444_4444, 1'b1};
        vecs[5] = '{1'b0, 32'h3FF, 3'b100, 32'h0000_005A, 1'b0};
        vecs[6] = '{1'b1, 32'h3FC, 3'b010, 32'h5555_5555, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].typ, 32'hA5A5_A5A5, vecs[i].rdval, g, wc, rv, er, rd);
            exp_wr = (vecs[i].we && !vecs[i].exp_err) ? 1 : 0;
            exp_rd = (vecs[i].we || vecs[i].exp_err) ? 32'h0 : vecs[i].rdval;
            total++;
            if ({g, rv, er} !== {2'b11, vecs[i].exp_err})
                $display("[TB] FAIL err_vec%0d_flags got %b exp %b", i, {g, rv, er}, {2'b11, vecs[i].exp_err});
            else passed++;
            total++;
            if (wc !== exp_wr) $display("[TB] FAIL err_vec%0d_wr got %0d exp %0d", i, wc, exp_wr); else passed++;
            total++;
            if (rd !== exp_rd) $display("[TB] FAIL err_vec%0d_rdata got %h exp %h", i, rd, exp_rd); else passed++;
        end
    endtask

    task automatic test_arbitration();
        logic exp_b [4];
        logic found;
        int   wait_c;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_dat_o = 32'h1111_1111;
`ifdef DMEM_ARB_RR_EN
        exp_b[0] = 1'b0; exp_b[1] = 1'b1; exp_b[2] = 1'b0; exp_b[3] = 1'b1;
`else
        exp_b[0] = 1'b0; exp_b[1] = 1'b0; exp_b[2] = 1'b0; exp_b[3] = 1'b0;
`endif
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h100; a_type = 3'b010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h104; b_type = 3'b010;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            wait_c = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (a_gnt || b_gnt) begin
                    found = 1'b1;
                    wait_c = c;
                    break;
                end
            end
            total++;
            if (!found) $display("[TB] FAIL arb%0d_timeout got none exp gnt", k);
            else if ({a_gnt, b_gnt} !== {~exp_b[k], exp_b[k]})
                $display("[TB] FAIL arb%0d_winner got a=%b b=%b exp b=%b", k, a_gnt, b_gnt, exp_b[k]);
            else passed++;
            total++;
            if (wait_c !== ((k == 0) ? 0 : 2))
                $display("[TB] FAIL arb%0d_spacing got %0d exp %0d", k, wait_c, (k == 0) ? 0 : 2);
            else passed++;
        end
        a_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_gnt) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (found !== 1'b1) $display("[TB] FAIL arb_b_serviced got %b exp 1", found); else passed++;
        b_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic g, rv, er;
        int wc;
        logic [31:0] rd;
        logic seen_resp;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h40; a_type = 3'b010; a_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if ({a_gnt, mem_wr_en} !== 2'b11) $display("[TB] FAIL rstmid_access got %b exp 11", {a_gnt, mem_wr_en}); else passed++;
        a_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({mem_wr_en, a_gnt, a_rvalid} !== 3'b000)
            $display("[TB] FAIL rstmid_async got %b exp 000", {mem_wr_en, a_gnt, a_rvalid});
        else passed++;
        total++;
        if ({mem_addr, mem_dat_i, a_rdata} !== 96'h0)
            $display("[TB] FAIL rstmid_outputs got %h exp 0", {mem_addr, mem_dat_i, a_rdata});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_rvalid || b_rvalid || mem_wr_en || a_gnt) seen_resp = 1'b1;
        end
        total++;
        if (seen_resp !== 1'b0) $display("[TB] FAIL rstmid_no_resp got %b exp 0", seen_resp); else passed++;
        run_access(1'b0, 1'b0, 32'h80, 3'b010, 32'h0, 32'h0000_600D, g, wc, rv, er, rd);
        total++;
        if ({g, rv, er, rd} !== {3'b110, 32'h0000_600D})
            $display("[TB] FAIL rstmid_next got %h exp %h", {g, rv, er, rd}, {3'b110, 32'h0000_600D});
        else passed++;
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_type = 3'b000; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_type = 3'b000; b_wdata = 32'h0;
        mem_dat_o = 32'h0;
        test_reset();
        test_load_word();
        test_store_half_b();
        test_errors();
        test_arbitration();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_LIMIT, 32'h0000_0400, exclusive upper byte-address bound of data memory (256 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 a_req / b_req  in  1  request valid, port A (core load/store), port B (debug/DMA).
REQ-005 a_we / b_we  in  1  1 = store, 0 = load.
REQ-006 a_addr / b_addr  in  32  byte address.
REQ-007 a_type / b_type  in  3  access type: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 a_wdata / b_wdata  in  32  store data, right-aligned.
REQ-009 a_gnt / b_gnt  out  1  one-cycle pulse: request accepted.
REQ-010 a_rvalid / b_rvalid  out  1  one-cycle pulse: response valid.
REQ-011 a_rdata / b_rdata  out  32  load result; 0 for stores and errors.
REQ-012 a_err / b_err  out  1  qualified by rvalid: access rejected.
REQ-013 mem_wr_en  out  1  memory write strobe.
REQ-014 mem_addr  out  32  memory address.
REQ-015 mem_rw_type  out  3  memory access type.
REQ-016 mem_dat_i  out  32  memory write data.
REQ-017 mem_dat_o  in  32  memory read data, combinational from mem_addr/mem_rw_type.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on edge with any req; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 On IDLE->ACCESS, winner's we/addr/type/wdata and port ID latched; later input changes ignored.
REQ-020 gnt of winner high for exactly the ACCESS cycle; req is held until gnt, deasserting req earlier withdraws it.
REQ-021 In ACCESS, mem_addr/mem_rw_type/mem_dat_i driven from latched values; outside ACCESS all mem outputs 0.
REQ-022 mem_wr_en = 1 only in ACCESS with latched we=1 and no error.
REQ-023 Load: mem_dat_o sampled at ACCESS->RESP edge into winner's rdata; rdata holds until that port's next response.
REQ-024 rvalid and err of winner high for exactly the RESP cycle; latency req-sampled edge to rvalid = 2 cycles; max throughput 1 access per 3 cycles.
REQ-025 Error when: type in {011,110,111}; half with addr[0]=1; word with addr[1:0]!=0; addr >= ADDR_LIMIT; on error no write, rdata = 0, err = 1.
REQ-026 Non-winning port's gnt/rvalid/err stay 0; its request remains pending and is arbitrated in next IDLE cycle.
REQ-027 Both req in same IDLE cycle: winner per REQ-033.

Reset
REQ-028 rst asserted: state IDLE, all gnt/rvalid/err 0, rdata 0, latched request cleared, mem outputs 0, immediately (asynchronous).
REQ-029 Reset during ACCESS aborts access; mem_wr_en falls with rst, no partial write after deassertion, no response issued.
REQ-030 First arbitration on first rising edge after rst deasserts.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN selects arbitration policy.
REQ-032 Without macro: fixed priority, A always wins ties.
REQ-033 With macro: round-robin; 1-bit last-winner register, reset to B (A wins first tie); on tie the port not last granted wins; register updates only on grant.

Verification
REQ-034 A load word addr 0x10, mem_dat_o=0xDEADBEEF -> a_gnt cycle 1, a_rvalid cycle 2, a_rdata=0xDEADBEEF, a_err=0.
REQ-035 B store half addr 0x22 data 0x1234 -> mem_wr_en=1 one cycle, mem_addr=0x22, mem_rw_type=001, mem_dat_i=0x1234; b_rvalid=1, b_err=0.
REQ-036 A store word addr 0x13 -> mem_wr_en never 1, a_rvalid=1, a_err=1, a_rdata=0; same for addr 0x400.
REQ-037 A and B req held 4 accesses -> without macro A,A,A,A; with macro A,B,A,B; B never lost.
REQ-038 rst pulsed mid-ACCESS of store -> mem_wr_en drops same cycle, no rvalid, all outputs 0; next request serviced normally.
